// File: rtl/mdio_pkg.sv
// Shared constants, FSM state type and frame builder for the Clause-22 MDIO master.
package mdio_pkg;

    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;

    localparam int MDIO_PRE_LEN   = 32;
    localparam int MDIO_FRAME_LEN = 64;
    localparam int MDIO_TA_BIT    = 46;
    localparam int MDIO_DATA_BIT  = 48;
    localparam int BMSR_LINK_BIT  = 2;

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        DONE
    } mdio_state_e;

    // Read frames carry all-ones in TA/DATA; those bits go out with the pad released.
    function automatic logic [MDIO_FRAME_LEN-1:0] mdio_build_frame(
        input logic        rd,
        input logic [4:0]  phyad,
        input logic [4:0]  regad,
        input logic [15:0] wrdata
    );
        return {{MDIO_PRE_LEN{1'b1}}, MDIO_ST, (rd ? MDIO_OP_RD : MDIO_OP_WR),
                phyad, regad, (rd ? 2'b11 : 2'b10), (rd ? 16'hFFFF : wrdata)};
    endfunction

endpackage

// File: rtl/mdio_master_if.sv
// MIIM request/response bundle between the MAC wrapper and the MDIO master.
interface mdio_master_if;
    // Handshake: miim_wren/miim_rden are single-cycle strobes taken only while
    // miim_busy is low (wren wins over rden); strobes seen while busy are dropped.
    // miim_rddata is valid in the cycle miim_rddata_valid is high and holds after.
    logic [4:0]  miim_phyad;
    logic [4:0]  miim_regad;
    logic [15:0] miim_wrdata;
    logic        miim_wren;
    logic        miim_rden;
    logic [15:0] miim_rddata;
    logic        miim_rddata_valid;
    logic        miim_busy;

    modport master (
        output miim_phyad, miim_regad, miim_wrdata, miim_wren, miim_rden,
        input  miim_rddata, miim_rddata_valid, miim_busy
    );

    modport slave (
        input  miim_phyad, miim_regad, miim_wrdata, miim_wren, miim_rden,
        output miim_rddata, miim_rddata_valid, miim_busy
    );
endinterface

// File: rtl/mdio_clk_gen.sv
// MDC divider: CLK_DIV cycles low then CLK_DIV cycles high, held low while disabled.
module mdio_clk_gen #(
    parameter int CLK_DIV = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic mdc,
    output logic rise,
    output logic fall
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] cnt;
    logic          last;

    assign last = en && (cnt == DW'(CLK_DIV - 1));
    // Strobes mark the cycle whose closing edge toggles mdc.
    assign rise = last && !mdc;
    assign fall = last && mdc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            mdc <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            mdc <= 1'b0;
        end else if (last) begin
            cnt <= '0;
            mdc <= ~mdc;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: serialises MIIM requests and round-robin polls PHY link status.
module mdio_master
    import mdio_pkg::*;
#(
    parameter int         CLK_DIV     = 20,
    parameter int         NUM_PHY     = 1,
    parameter int         POLL_PERIOD = 1000000,
    parameter logic [4:0] POLL_REGAD  = 5'd1
) (
    input  logic               clk,
    input  logic               reset,
    mdio_master_if.slave       miim,
    output logic               mdc,
    input  logic               mdio_in,
    output logic               mdio_out,
    output logic               mdio_oen,
    input  logic               poll_en,
    input  logic [4:0]         poll_phyad_base,
    output logic [NUM_PHY-1:0] link_status,
    output logic               link_change,
    output mdio_state_e        state_dbg
);

    localparam int IDXW = (NUM_PHY > 1) ? $clog2(NUM_PHY) : 1;
    localparam int PTW  = $clog2(POLL_PERIOD + 1);

    mdio_state_e         state_q, state_d;
    logic                accept_wr, accept_rd, launch_poll, start;
    logic                mdc_rise, mdc_fall, frame_end;
    logic [63:0]         frame_sr;
    logic [5:0]          bit_cnt;
    logic                is_read, is_poll;
    logic [15:0]         rd_sr;
    logic [PTW-1:0]      poll_timer;
    logic                timer_full;
    logic [IDXW-1:0]     idx;
    logic [4:0]          poll_phy;
    logic [NUM_PHY-1:0]  ls_next;

    mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk  (clk),
        .rst  (reset),
        .en   (state_q == FRAME),
        .mdc  (mdc),
        .rise (mdc_rise),
        .fall (mdc_fall)
    );

    assign timer_full     = (poll_timer == PTW'(POLL_PERIOD));
    assign poll_phy       = poll_phyad_base + 5'(idx);
    assign start          = accept_wr || accept_rd || launch_poll;
    assign frame_end      = (state_q == FRAME) && mdc_fall && (bit_cnt == 6'd63);
    assign miim.miim_busy = (state_q != IDLE);
    assign state_dbg      = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        accept_wr   = 1'b0;
        accept_rd   = 1'b0;
        launch_poll = 1'b0;
        case (state_q)
            IDLE: begin
                if (miim.miim_wren)              accept_wr   = 1'b1;
                else if (miim.miim_rden)         accept_rd   = 1'b1;
                else if (poll_en && timer_full)  launch_poll = 1'b1;
                if (accept_wr || accept_rd || launch_poll) state_d = FRAME;
            end
            FRAME:   if (frame_end) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Link table with the finishing poll's BMSR link bit folded in.
    always_comb begin
        ls_next = link_status;
        for (int i = 0; i < NUM_PHY; i++) begin
            if (idx == IDXW'(i)) ls_next[i] = rd_sr[BMSR_LINK_BIT];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_sr               <= '1;
            bit_cnt                <= '0;
            is_read                <= 1'b0;
            is_poll                <= 1'b0;
            rd_sr                  <= '0;
            mdio_out               <= 1'b1;
            mdio_oen               <= 1'b1;
            miim.miim_rddata       <= '0;
            miim.miim_rddata_valid <= 1'b0;
            link_status            <= '0;
            link_change            <= 1'b0;
        end else begin
            miim.miim_rddata_valid <= 1'b0;
            link_change            <= 1'b0;
            if (start) begin
                frame_sr <= mdio_build_frame(!accept_wr,
                                             launch_poll ? poll_phy : miim.miim_phyad,
                                             launch_poll ? POLL_REGAD : miim.miim_regad,
                                             miim.miim_wrdata);
                bit_cnt  <= '0;
                is_read  <= !accept_wr;
                is_poll  <= launch_poll;
                mdio_out <= 1'b1;
                mdio_oen <= 1'b0;
            end else if (mdc_fall) begin
                if (bit_cnt == 6'd63) begin
                    mdio_out <= 1'b1;
                    mdio_oen <= 1'b1;
                    if (is_read && !is_poll) begin
                        miim.miim_rddata       <= rd_sr;
                        miim.miim_rddata_valid <= 1'b1;
                    end
                    if (is_poll) begin
                        link_status <= ls_next;
                        link_change <= (ls_next != link_status);
                    end
                end else begin
                    frame_sr <= frame_sr << 1;
                    mdio_out <= frame_sr[62];
                    bit_cnt  <= bit_cnt + 1'b1;
                    // Release the pad from the first turnaround bit of a read.
                    if (is_read && bit_cnt == 6'(MDIO_TA_BIT - 1)) mdio_oen <= 1'b1;
                end
            end
            if (mdc_rise && bit_cnt >= 6'(MDIO_DATA_BIT)) rd_sr <= {rd_sr[14:0], mdio_in};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                     poll_timer <= '0;
        else if (!poll_en || launch_poll) poll_timer <= '0;
        else if (!timer_full)          poll_timer <= poll_timer + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
        end else if (frame_end && is_poll) begin
            idx <= (idx == IDXW'(NUM_PHY - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_mdio_master.sv
// Scoreboard bench for mdio_master: pad-level frame monitor, PHY model, directed requests.
module tb_mdio_master;
    import mdio_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mdc, mdio_in, mdio_out, mdio_oen, poll_en, link_change;
    logic [4:0]  poll_phyad_base;
    logic [1:0]  link_status;
    mdio_state_e state_dbg;

    mdio_master_if miim_if();

    mdio_master #(.CLK_DIV(2), .NUM_PHY(2), .POLL_PERIOD(100), .POLL_REGAD(5'd1)) dut (
        .clk             (clk),
        .reset           (rst),
        .miim            (miim_if),
        .mdc             (mdc),
        .mdio_in         (mdio_in),
        .mdio_out        (mdio_out),
        .mdio_oen        (mdio_oen),
        .poll_en         (poll_en),
        .poll_phyad_base (poll_phyad_base),
        .link_status     (link_status),
        .link_change     (link_change),
        .state_dbg       (state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_oen_q[$];
    logic [15:0] exp_rd_q[$];

    int          mon_bit = 0;
    logic [63:0] cap = '0;
    logic [63:0] oenv = '0;
    logic        prev_mdc = 1'b0;
    logic [15:0] phy_reg = 16'hFFFF;
    logic        phy_drive;
    int          busy_len = 0;
    int          valid_cnt = 0;
    int          change_cnt = 0;
    int          frame_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] phy_reply(input logic [4:0] pa, input logic [4:0] ra);
        if (pa == 5'd3 && ra == 5'd2) return 16'h796D;
        if (pa == 5'd5 && ra == 5'd1) return 16'h0004;
        if (pa == 5'd4 && ra == 5'd1) return 16'h0000;
        return 16'hDEAD;
    endfunction

    // PHY model: drives TA low on the second turnaround bit, then its register MSB first.
    always_comb begin
        phy_drive = 1'b1;
        if (mon_bit == 47) phy_drive = 1'b0;
        else if (mon_bit >= 48 && mon_bit < 64) phy_drive = phy_reg[4'(63 - mon_bit)];
    end
    assign mdio_in = mdio_oen ? phy_drive : mdio_out;

    // Monitor: sample the pad at each mdc rise and score complete frames.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_bit  = 0;
                busy_len = 0;
                prev_mdc = 1'b0;
            end else begin
                if (mdc && !prev_mdc) begin
                    cap  = {cap[62:0], mdio_in};
                    oenv = {oenv[62:0], mdio_oen};
                    mon_bit++;
                    if (mon_bit == 46) phy_reg = phy_reply(cap[9:5], cap[4:0]);
                    if (mon_bit == 64) begin
                        frame_cnt++;
                        mon_bit = 0;
                        if (exp_q.size() == 0) begin
                            checks++;
                            fails++;
                            $display("FAIL unexpected_frame: got %0h expected none", cap);
                        end else begin
                            check("frame_bits", cap, exp_q.pop_front());
                            check("frame_oen", oenv, exp_oen_q.pop_front());
                        end
                    end
                end
                if (!miim_if.miim_busy) mon_bit = 0;
                prev_mdc = mdc;
                if (miim_if.miim_busy) begin
                    busy_len++;
                end else if (busy_len != 0) begin
                    check("busy_len", 64'(busy_len), 64'd257);
                    busy_len = 0;
                end
                if (miim_if.miim_rddata_valid) begin
                    valid_cnt++;
                    if (exp_rd_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_rddata_valid: got %0h expected none", miim_if.miim_rddata);
                    end else begin
                        check("rddata", miim_if.miim_rddata, exp_rd_q.pop_front());
                    end
                end
                if (link_change) change_cnt++;
            end
        end
    end

    task automatic do_req(input logic wr, input logic rd, input logic [4:0] pa,
                          input logic [4:0] ra, input logic [15:0] d);
        miim_if.miim_phyad  = pa;
        miim_if.miim_regad  = ra;
        miim_if.miim_wrdata = d;
        miim_if.miim_wren   = wr;
        miim_if.miim_rden   = rd;
        @(negedge clk);
        miim_if.miim_wren   = 1'b0;
        miim_if.miim_rden   = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input int budget, input string name);
        int n = 0;
        while (miim_if.miim_busy !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(miim_if.miim_busy), 64'(lvl));
    endtask

    task automatic check_reset_vals();
        check("rst_mdc", 64'(mdc), 64'd0);
        check("rst_mdio_out", 64'(mdio_out), 64'd1);
        check("rst_mdio_oen", 64'(mdio_oen), 64'd1);
        check("rst_busy", 64'(miim_if.miim_busy), 64'd0);
        check("rst_rddata", 64'(miim_if.miim_rddata), 64'd0);
        check("rst_rddata_valid", 64'(miim_if.miim_rddata_valid), 64'd0);
        check("rst_link_status", 64'(link_status), 64'd0);
        check("rst_link_change", 64'(link_change), 64'd0);
        check("rst_state", 64'(state_dbg), 64'(IDLE));
    endtask

    localparam logic [63:0] OEN_WR = 64'h0;
    localparam logic [63:0] OEN_RD = 64'h0000_0000_0003_FFFF;

    initial begin
        int n;
        miim_if.miim_phyad  = '0;
        miim_if.miim_regad  = '0;
        miim_if.miim_wrdata = '0;
        miim_if.miim_wren   = 1'b0;
        miim_if.miim_rden   = 1'b0;
        poll_en             = 1'b0;
        poll_phyad_base     = 5'd0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;

        // Write phy 1 reg 0 = 0x1200
        @(negedge clk);
        exp_q.push_back(64'hFFFF_FFFF_5082_1200); exp_oen_q.push_back(OEN_WR);
        do_req(1'b1, 1'b0, 5'd1, 5'd0, 16'h1200);
        wait_busy(1'b0, 400, "wr_done");

        // Read phy 3 reg 2 -> 0x796D
        @(negedge clk);
        exp_q.push_back(64'hFFFF_FFFF_618A_796D); exp_oen_q.push_back(OEN_RD);
        exp_rd_q.push_back(16'h796D);
        do_req(1'b0, 1'b1, 5'd3, 5'd2, 16'h0);
        wait_busy(1'b0, 400, "rd_done");
        check("rddata_hold", 64'(miim_if.miim_rddata), 64'h796D);

        // wren+rden together is a write; rden mid-frame is dropped
        @(negedge clk);
        exp_q.push_back(64'hFFFF_FFFF_5126_0F0F); exp_oen_q.push_back(OEN_WR);
        do_req(1'b1, 1'b1, 5'd2, 5'd9, 16'h0F0F);
        repeat (100) @(negedge clk);
        do_req(1'b0, 1'b1, 5'd3, 5'd2, 16'h0);
        wait_busy(1'b0, 400, "both_done");
        n = 0;
        repeat (300) begin
            @(negedge clk);
            if (miim_if.miim_busy) n++;
        end
        check("no_second_frame", 64'(n), 64'd0);

        // Polling PHY4 (link down) then PHY5 (link up)
        poll_phyad_base = 5'd4;
        exp_q.push_back(64'hFFFF_FFFF_6206_0000); exp_oen_q.push_back(OEN_RD);
        exp_q.push_back(64'hFFFF_FFFF_6286_0004); exp_oen_q.push_back(OEN_RD);
        @(negedge clk);
        poll_en = 1'b1;
        wait_busy(1'b1, 200, "poll0_start");
        wait_busy(1'b0, 400, "poll0_done");
        wait_busy(1'b1, 50, "poll1_start");
        @(negedge clk);
        poll_en = 1'b0;
        wait_busy(1'b0, 400, "poll1_done");
        check("poll_link_status", 64'(link_status), 64'h2);
        check("poll_link_change_cnt", 64'(change_cnt), 64'd1);
        check("poll_no_rd_valid", 64'(valid_cnt), 64'd1);

        // User read collides with a poll launch: user frame first
        exp_q.push_back(64'hFFFF_FFFF_5392_BEEF); exp_oen_q.push_back(OEN_WR);
        exp_q.push_back(64'hFFFF_FFFF_618A_796D); exp_oen_q.push_back(OEN_RD);
        exp_rd_q.push_back(16'h796D);
        exp_q.push_back(64'hFFFF_FFFF_6206_0000); exp_oen_q.push_back(OEN_RD);
        @(negedge clk);
        poll_en = 1'b1;
        do_req(1'b1, 1'b0, 5'd7, 5'd4, 16'hBEEF);
        wait_busy(1'b0, 400, "race_wr_done");
        do_req(1'b0, 1'b1, 5'd3, 5'd2, 16'h0);
        wait_busy(1'b0, 400, "race_rd_done");
        wait_busy(1'b1, 5, "race_poll_start");
        @(negedge clk);
        poll_en = 1'b0;
        wait_busy(1'b0, 400, "race_poll_done");
        check("race_link_status", 64'(link_status), 64'h2);

        // Reset during bit 40 of a read, then a clean frame
        @(negedge clk);
        exp_q.push_back(64'hFFFF_FFFF_618A_796D); exp_oen_q.push_back(OEN_RD);
        exp_rd_q.push_back(16'h796D);
        do_req(1'b0, 1'b1, 5'd3, 5'd2, 16'h0);
        n = 0;
        while (mon_bit < 40 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reach_bit40", 64'(mon_bit), 64'd40);
        rst = 1'b1;
        #1;
        check_reset_vals();
        exp_q.delete();
        exp_oen_q.delete();
        exp_rd_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_q.push_back(64'hFFFF_FFFF_5392_BEEF); exp_oen_q.push_back(OEN_WR);
        do_req(1'b1, 1'b0, 5'd7, 5'd4, 16'hBEEF);
        wait_busy(1'b0, 400, "post_rst_done");

        repeat (10) @(negedge clk);
        check("frames_left", 64'(exp_q.size()), 64'd0);
        check("rd_left", 64'(exp_rd_q.size()), 64'd0);
        check("frame_cnt", 64'(frame_cnt), 64'd9);
        check("valid_cnt", 64'(valid_cnt), 64'd2);
        check("change_cnt", 64'(change_cnt), 64'd1);
        check("final_link_status", 64'(link_status), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
